// File: rtl/tod_master_stream_gen_if.sv
// Load handshake and ToD stream bundle for tod_master_stream_gen.
// The master modport is the generator side; the slave modport is the
// side that requests time loads and consumes the ToD stream.
interface tod_master_stream_gen_if #(
    parameter int unsigned SEC_W = 48
);
    logic                  load_valid;
    logic                  load_ready;
    logic [SEC_W+47:0]     load_data;
    logic                  load_err;
    logic [SEC_W+47:0]     master_tod_data;
    logic                  master_tod_valid;

    modport master (
        input  load_valid,
        input  load_data,
        output load_ready,
        output load_err,
        output master_tod_data,
        output master_tod_valid
    );

    modport slave (
        output load_valid,
        output load_data,
        input  load_ready,
        input  load_err,
        input  master_tod_data,
        input  master_tod_valid
    );
endinterface

// File: rtl/tod_master_stream_gen.sv
// Master time-of-day generator.
// Keeps a free-running {seconds, nanoseconds, fractional ns} counter that
// advances by a programmable period, accepts atomic time loads with range
// checking, and streams the registered ToD with a valid qualifier.
// Optional build macro TOD_MASTER_PPS_EN adds a pps output that pulses
// for PPS_WIDTH cycles whenever the streamed seconds field increments.
module tod_master_stream_gen #(
    parameter int unsigned SEC_W            = 48,
    parameter int unsigned NS_MAX           = 1000000000,
    parameter logic [3:0]  RESET_PERIOD_NS  = 4'd6,
    parameter logic [15:0] RESET_PERIOD_FNS = 16'h6666
`ifdef TOD_MASTER_PPS_EN
    ,
    parameter int unsigned PPS_WIDTH        = 16
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          cfg_period_valid,
    input  logic [3:0]                    cfg_period_ns,
    input  logic [15:0]                   cfg_period_fns,
    tod_master_stream_gen_if.master       tod_if
`ifdef TOD_MASTER_PPS_EN
    ,
    output logic                          pps
`endif
);

    localparam logic [32:0] NS_MAX_W = 33'(NS_MAX);

    typedef enum logic [0:0] {
        UNSET = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state_q;
    logic [SEC_W-1:0]   sec_q, sec_d, secInc;
    logic [31:0]        ns_q, ns_d, nsInc;
    logic [15:0]        fns_q, fns_d, fnsInc;
    logic [3:0]         periodNs_q;
    logic [15:0]        periodFns_q;
    logic               loadReady_q;
    logic               loadErr_q;
    logic [SEC_W+47:0]  todData_q;
    logic               todValid_q;

    logic [16:0]        fsum;
    logic [32:0]        nsum;
    logic               secCarry;
    logic               accept;
    logic               loadOk;
    logic               loadApply;
    logic               secStep_d;

    // One period step of the counter, with fractional carry into ns and ns rollover into seconds.
    always_comb begin
        fsum     = {1'b0, fns_q} + {1'b0, periodFns_q};
        nsum     = {1'b0, ns_q} + {29'd0, periodNs_q} + {32'd0, fsum[16]};
        secCarry = (nsum >= NS_MAX_W);
        fnsInc   = fsum[15:0];
        if (secCarry) begin
            nsInc  = nsum[31:0] - NS_MAX_W[31:0];
            secInc = sec_q + SEC_W'(1);
        end else begin
            nsInc  = nsum[31:0];
            secInc = sec_q;
        end
    end

    // Choose the next counter value: a valid load wins, otherwise increment when enabled.
    always_comb begin
        accept    = tod_if.load_valid && loadReady_q;
        loadOk    = ({1'b0, tod_if.load_data[47:16]} < NS_MAX_W);
        loadApply = accept && loadOk;
        sec_d     = sec_q;
        ns_d      = ns_q;
        fns_d     = fns_q;
        secStep_d = 1'b0;
        if (loadApply) begin
            sec_d = tod_if.load_data[SEC_W+47:48];
            ns_d  = tod_if.load_data[47:16];
            fns_d = tod_if.load_data[15:0];
        end else if (enable) begin
            sec_d     = secInc;
            ns_d      = nsInc;
            fns_d     = fnsInc;
            secStep_d = secCarry;
        end
    end

    // Counter, period, load handshake, FSM and registered stream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= UNSET;
            sec_q       <= '0;
            ns_q        <= '0;
            fns_q       <= '0;
            periodNs_q  <= RESET_PERIOD_NS;
            periodFns_q <= RESET_PERIOD_FNS;
            loadReady_q <= 1'b1;
            loadErr_q   <= 1'b0;
            todData_q   <= '0;
            todValid_q  <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            ns_q        <= ns_d;
            fns_q       <= fns_d;
            if (cfg_period_valid) begin
                periodNs_q  <= cfg_period_ns;
                periodFns_q <= cfg_period_fns;
            end
            loadReady_q <= !accept;
            loadErr_q   <= accept && !loadOk;
            todData_q   <= {sec_q, ns_q, fns_q};
            todValid_q  <= (state_q == RUN);
            case (state_q)
                UNSET:   if (loadApply) state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= UNSET;
            endcase
        end
    end

    assign tod_if.load_ready       = loadReady_q;
    assign tod_if.load_err         = loadErr_q;
    assign tod_if.master_tod_data  = todData_q;
    assign tod_if.master_tod_valid = todValid_q;

`ifdef TOD_MASTER_PPS_EN
    localparam int unsigned PPS_CNT_W = $clog2(PPS_WIDTH + 1);

    logic                 secStep_q;
    logic                 pps_q;
    logic [PPS_CNT_W-1:0] ppsCnt_q;

    // Start the pulse when an incremented seconds value reaches the output register; loads never trigger it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            secStep_q <= 1'b0;
            pps_q     <= 1'b0;
            ppsCnt_q  <= '0;
        end else begin
            secStep_q <= secStep_d;
            if (state_q != RUN) begin
                pps_q    <= 1'b0;
                ppsCnt_q <= '0;
            end else if (secStep_q) begin
                pps_q    <= 1'b1;
                ppsCnt_q <= PPS_CNT_W'(PPS_WIDTH - 1);
            end else if (ppsCnt_q != '0) begin
                ppsCnt_q <= ppsCnt_q - PPS_CNT_W'(1);
            end else begin
                pps_q <= 1'b0;
            end
        end
    end

    assign pps = pps_q;
`else
    logic unusedSecStep;
    assign unusedSecStep = secStep_d;
`endif

endmodule

// File: tb/tb_tod_master_stream_gen.sv
// Directed testbench for tod_master_stream_gen.
// Each task drives one scenario from a fresh reset and checks the streamed
// ToD, handshake and error outputs against hand-computed values.
module tb_tod_master_stream_gen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        cfgPeriodValid;
    logic [3:0]  cfgPeriodNs;
    logic [15:0] cfgPeriodFns;
`ifdef TOD_MASTER_PPS_EN
    logic        pps;
`endif

    int vecCount  = 0;
    int missCount = 0;

    tod_master_stream_gen_if #(.SEC_W(48)) tif ();

    tod_master_stream_gen dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .cfg_period_valid (cfgPeriodValid),
        .cfg_period_ns    (cfgPeriodNs),
        .cfg_period_fns   (cfgPeriodFns),
        .tod_if           (tif)
`ifdef TOD_MASTER_PPS_EN
        ,
        .pps              (pps)
`endif
    );

    // 10 ns master ToD clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for two cycles with quiet inputs, release on a falling edge.
    task automatic doReset();
        reset_n        = 1'b0;
        enable         = 1'b1;
        cfgPeriodValid = 1'b0;
        cfgPeriodNs    = 4'd0;
        cfgPeriodFns   = 16'h0;
        tif.load_valid = 1'b0;
        tif.load_data  = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [95:0] expTab [1:7];
        int validHigh;
        reset_n        = 1'b0;
        enable         = 1'b1;
        cfgPeriodValid = 1'b0;
        cfgPeriodNs    = 4'd0;
        cfgPeriodFns   = 16'h0;
        tif.load_valid = 1'b0;
        tif.load_data  = '0;
        @(negedge clk);
        vecCount++;
        if (tif.master_tod_data !== 96'd0) begin
            missCount++;
            $display("[TB] FAIL reset_data got=%h exp=%h", tif.master_tod_data, 96'd0);
        end
        vecCount++;
        if (tif.master_tod_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_valid got=%b exp=0", tif.master_tod_valid);
        end
        vecCount++;
        if (tif.load_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_ready got=%b exp=1", tif.load_ready);
        end
        vecCount++;
        if (tif.load_err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_err got=%b exp=0", tif.load_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        expTab[1] = {48'd0, 32'd0,  16'h0000};
        expTab[2] = {48'd0, 32'd6,  16'h6666};
        expTab[3] = {48'd0, 32'd12, 16'hCCCC};
        expTab[4] = {48'd0, 32'd19, 16'h3332};
        expTab[5] = {48'd0, 32'd25, 16'h9998};
        expTab[6] = {48'd0, 32'd31, 16'hFFFE};
        expTab[7] = {48'd0, 32'd38, 16'h6664};
        for (int k = 1; k <= 7; k++) begin
            tick();
            vecCount++;
            if (tif.master_tod_data !== expTab[k]) begin
                missCount++;
                $display("[TB] FAIL free_run_%0d got=%h exp=%h", k, tif.master_tod_data, expTab[k]);
            end
        end
        validHigh = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tif.master_tod_valid !== 1'b0) validHigh++;
        end
        vecCount++;
        if (validHigh !== 0) begin
            missCount++;
            $display("[TB] FAIL unset_valid got=%0d high cycles exp=0", validHigh);
        end
    endtask

    task automatic test_load_reject();
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd3, 32'd1000000000, 16'h0};
        tick();
        tif.load_valid = 1'b0;
        vecCount++;
        if (tif.load_err !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reject_err_pulse got=%b exp=1", tif.load_err);
        end
        vecCount++;
        if (tif.load_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reject_ready_low got=%b exp=0", tif.load_ready);
        end
        tick();
        vecCount++;
        if (tif.load_err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reject_err_end got=%b exp=0", tif.load_err);
        end
        vecCount++;
        if (tif.load_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reject_ready_back got=%b exp=1", tif.load_ready);
        end
        vecCount++;
        if (tif.master_tod_data !== {48'd0, 32'd6, 16'h6666}) begin
            missCount++;
            $display("[TB] FAIL reject_counter got=%h exp=%h", tif.master_tod_data, {48'd0, 32'd6, 16'h6666});
        end
        tick();
        vecCount++;
        if (tif.master_tod_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reject_state got=%b exp=0", tif.master_tod_valid);
        end
        vecCount++;
        if (tif.master_tod_data !== {48'd0, 32'd12, 16'hCCCC}) begin
            missCount++;
            $display("[TB] FAIL reject_counter2 got=%h exp=%h", tif.master_tod_data, {48'd0, 32'd12, 16'hCCCC});
        end
    endtask

    task automatic test_load_accept();
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd5, 32'd999999990, 16'h0};
        tick();
        tif.load_valid = 1'b0;
        vecCount++;
        if (tif.load_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL accept_ready_low got=%b exp=0", tif.load_ready);
        end
        vecCount++;
        if (tif.master_tod_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL accept_valid_early got=%b exp=0", tif.master_tod_valid);
        end
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd5, 32'd999999990, 16'h0}) begin
            missCount++;
            $display("[TB] FAIL accept_data got=%h exp=%h", tif.master_tod_data, {48'd5, 32'd999999990, 16'h0});
        end
        vecCount++;
        if (tif.master_tod_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL accept_valid got=%b exp=1", tif.master_tod_valid);
        end
        vecCount++;
        if (tif.load_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL accept_ready_back got=%b exp=1", tif.load_ready);
        end
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd5, 32'd999999996, 16'h6666}) begin
            missCount++;
            $display("[TB] FAIL accept_step1 got=%h exp=%h", tif.master_tod_data, {48'd5, 32'd999999996, 16'h6666});
        end
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd6, 32'd2, 16'hCCCC}) begin
            missCount++;
            $display("[TB] FAIL accept_sec_roll got=%h exp=%h", tif.master_tod_data, {48'd6, 32'd2, 16'hCCCC});
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd7, 32'd100, 16'h0};
        tick();
        tif.load_data  = {48'd9, 32'd9, 16'h9};
        vecCount++;
        if (tif.load_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_ready_low got=%b exp=0", tif.load_ready);
        end
        tick();
        tif.load_valid = 1'b0;
        vecCount++;
        if (tif.master_tod_data !== {48'd7, 32'd100, 16'h0}) begin
            missCount++;
            $display("[TB] FAIL b2b_first got=%h exp=%h", tif.master_tod_data, {48'd7, 32'd100, 16'h0});
        end
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd7, 32'd106, 16'h6666}) begin
            missCount++;
            $display("[TB] FAIL b2b_no_reaccept got=%h exp=%h", tif.master_tod_data, {48'd7, 32'd106, 16'h6666});
        end
    endtask

    task automatic test_period_update();
        logic [95:0] expTab [0:4];
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = '0;
        tick();
        tif.load_valid = 1'b0;
        cfgPeriodValid = 1'b1;
        cfgPeriodNs    = 4'd3;
        cfgPeriodFns   = 16'h2000;
        expTab[0] = {48'd0, 32'd0,  16'h0000};
        expTab[1] = {48'd0, 32'd6,  16'h6666};
        expTab[2] = {48'd0, 32'd9,  16'h8666};
        expTab[3] = {48'd0, 32'd12, 16'hA666};
        expTab[4] = {48'd0, 32'd15, 16'hC666};
        for (int k = 0; k <= 4; k++) begin
            tick();
            cfgPeriodValid = 1'b0;
            vecCount++;
            if (tif.master_tod_data !== expTab[k]) begin
                missCount++;
                $display("[TB] FAIL period_%0d got=%h exp=%h", k, tif.master_tod_data, expTab[k]);
            end
        end
    endtask

    task automatic test_enable_hold();
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd1, 32'd500, 16'h0};
        tick();
        tif.load_valid = 1'b0;
        enable         = 1'b0;
        repeat (3) tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd1, 32'd500, 16'h0}) begin
            missCount++;
            $display("[TB] FAIL hold_before got=%h exp=%h", tif.master_tod_data, {48'd1, 32'd500, 16'h0});
        end
        vecCount++;
        if (tif.master_tod_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL hold_valid got=%b exp=1", tif.master_tod_valid);
        end
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd2, 32'd0, 16'h1234};
        tick();
        tif.load_valid = 1'b0;
        vecCount++;
        if (tif.master_tod_data !== {48'd1, 32'd500, 16'h0}) begin
            missCount++;
            $display("[TB] FAIL hold_load_lat got=%h exp=%h", tif.master_tod_data, {48'd1, 32'd500, 16'h0});
        end
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd2, 32'd0, 16'h1234}) begin
            missCount++;
            $display("[TB] FAIL hold_loaded got=%h exp=%h", tif.master_tod_data, {48'd2, 32'd0, 16'h1234});
        end
        repeat (5) tick();
        enable = 1'b1;
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd2, 32'd0, 16'h1234}) begin
            missCount++;
            $display("[TB] FAIL hold_still got=%h exp=%h", tif.master_tod_data, {48'd2, 32'd0, 16'h1234});
        end
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd2, 32'd6, 16'h789A}) begin
            missCount++;
            $display("[TB] FAIL hold_resume got=%h exp=%h", tif.master_tod_data, {48'd2, 32'd6, 16'h789A});
        end
    endtask

    task automatic test_sec_wrap();
`ifdef TOD_MASTER_PPS_EN
        int ppsHigh;
`endif
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'hFFFF_FFFF_FFFF, 32'd999999999, 16'h0};
        tick();
        tif.load_valid = 1'b0;
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'hFFFF_FFFF_FFFF, 32'd999999999, 16'h0}) begin
            missCount++;
            $display("[TB] FAIL wrap_loaded got=%h exp=%h", tif.master_tod_data, {48'hFFFF_FFFF_FFFF, 32'd999999999, 16'h0});
        end
`ifdef TOD_MASTER_PPS_EN
        vecCount++;
        if (pps !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL pps_on_load got=%b exp=0", pps);
        end
`endif
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd0, 32'd5, 16'h6666}) begin
            missCount++;
            $display("[TB] FAIL wrap_sec got=%h exp=%h", tif.master_tod_data, {48'd0, 32'd5, 16'h6666});
        end
`ifdef TOD_MASTER_PPS_EN
        vecCount++;
        if (pps !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL pps_rise got=%b exp=1", pps);
        end
        ppsHigh = (pps === 1'b1) ? 1 : 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (pps === 1'b1) ppsHigh++;
        end
        vecCount++;
        if (ppsHigh !== 16) begin
            missCount++;
            $display("[TB] FAIL pps_width got=%0d exp=16", ppsHigh);
        end
        vecCount++;
        if (pps !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL pps_fall got=%b exp=0", pps);
        end
`endif
    endtask

    task automatic test_mid_reset();
        doReset();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd4, 32'd40, 16'h4};
        tick();
        tif.load_valid = 1'b0;
        tick();
        tif.load_valid = 1'b1;
        tif.load_data  = {48'd8, 32'd80, 16'h8};
        #2;
        reset_n = 1'b0;
        #1;
        vecCount++;
        if (tif.master_tod_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midrst_valid got=%b exp=0", tif.master_tod_valid);
        end
        vecCount++;
        if (tif.master_tod_data !== 96'd0) begin
            missCount++;
            $display("[TB] FAIL midrst_data got=%h exp=0", tif.master_tod_data);
        end
        vecCount++;
        if (tif.load_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL midrst_ready got=%b exp=1", tif.load_ready);
        end
        tif.load_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        vecCount++;
        if (tif.master_tod_data !== {48'd0, 32'd6, 16'h6666}) begin
            missCount++;
            $display("[TB] FAIL midrst_discard got=%h exp=%h", tif.master_tod_data, {48'd0, 32'd6, 16'h6666});
        end
        vecCount++;
        if (tif.master_tod_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midrst_unset got=%b exp=0", tif.master_tod_valid);
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        $display("[TB] start");
        test_reset();
        test_load_reject();
        test_load_accept();
        test_back_to_back();
        test_period_update();
        test_enable_hold();
        test_sec_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
